// File: rtl/cs_result_fifo.sv
// Result buffer behind the CS smoothing filter: skips the warm-up samples after reset,
// then queues one Y per clock in a first-word-fall-through FIFO with drop accounting.
module cs_result_fifo #(
  parameter int DW     = 10,
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int WARMUP = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] Y,
  input  logic          flush,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic [7:0]    drop_cnt
);

  localparam int CW = (WARMUP > 1) ? $clog2(WARMUP) : 1;

  typedef enum logic {WARM, RUN} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   warm_cnt, warm_cnt_next;
  logic [DW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            capture, push, pop, full, wr_en, drop;

  always_comb begin
    state_next    = state;
    warm_cnt_next = warm_cnt;
    capture       = 1'b0;
    case (state)
      WARM: begin
        if (WARMUP == 0) begin
          // No warm-up: the very first sample after reset is already valid.
          state_next = RUN;
          capture    = 1'b1;
        end else begin
          warm_cnt_next = warm_cnt + 1'b1;
          if (warm_cnt == CW'(WARMUP - 1))
            state_next = RUN;
        end
      end
      RUN:     capture = 1'b1;
      default: state_next = WARM;
    endcase
  end

  assign out_valid = (level != '0);
  assign full      = (level == (AW+1)'(DEPTH));
  assign pop       = out_valid & out_ready & ~flush;
  assign push      = capture & ~flush;
  // When full, a push only lands if the head leaves on the same edge.
  assign wr_en     = push & (~full | pop);
  assign drop      = push & full & ~pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= WARM;
      warm_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      state    <= state_next;
      warm_cnt <= warm_cnt_next;
      if (flush) begin
        rd_ptr <= wr_ptr;
        level  <= '0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + 1'b1;
        if (pop)   rd_ptr <= rd_ptr + 1'b1;
        if (wr_en & ~pop)
          level <= level + 1'b1;
        else if (pop & ~wr_en)
          level <= level - 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF)
          drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  // Storage carries no reset so it maps onto plain RAM; contents are qualified by level.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= Y;
  end

  assign out_data = mem[rd_ptr];

endmodule
